jtag_debug_sys_pio_ext: RTL and testbench



---
 rtl/pio_ext_pkg.sv | 12 +
 rtl/pio_ext_in_sync.sv | 37 +++
 rtl/jtag_debug_sys_pio_ext.sv | 76 +++++++
 tb/tb_jtag_debug_sys_pio_ext.sv | 201 ++++++++++++++++++++
 4 files changed

// File: rtl/pio_ext_pkg.sv
// pio_ext_pkg: register map, edge selection and arm-state types shared by the
// extended PIO slave and its input synchroniser.
package pio_ext_pkg;
    localparam logic [2:0] ADDR_DATA     = 3'd0;
    localparam logic [2:0] ADDR_DIR      = 3'd1;
    localparam logic [2:0] ADDR_IRQ_MASK = 3'd2;
    localparam logic [2:0] ADDR_EDGE_CAP = 3'd3;
    localparam logic [2:0] ADDR_OUTSET   = 3'd4;
    localparam logic [2:0] ADDR_OUTCLR   = 3'd5;
    typedef enum logic [1:0] {EDGE_RISE, EDGE_FALL, EDGE_ANY} edge_e;
    typedef enum logic {ARMING, ARMED} arm_e;
endpackage

// File: rtl/pio_ext_in_sync.sv
// pio_ext_in_sync: input synchroniser chain, one-cycle-delayed copy and
// per-bit edge pulse selected by EDGE_TYPE.
module pio_ext_in_sync
    import pio_ext_pkg::*;
#(
    parameter int WIDTH       = 32,
    parameter int SYNC_STAGES = 2,
    parameter int EDGE_TYPE   = 0
) (
    input  logic             clk,
    input  logic             i_reset_n,
    input  logic [WIDTH-1:0] i_in,
    output logic [WIDTH-1:0] o_sync,
    output logic [WIDTH-1:0] o_pulse
);
    logic [WIDTH-1:0] r_chain [SYNC_STAGES];
    logic [WIDTH-1:0] r_prev;
    logic [WIDTH-1:0] w_rise;
    logic [WIDTH-1:0] w_fall;

    always_ff @(posedge clk) begin
        if (!i_reset_n) begin
            for (int i = 0; i < SYNC_STAGES; i++) r_chain[i] <= '0;
            r_prev <= '0;
        end else begin
            r_chain[0] <= i_in;
            for (int i = 1; i < SYNC_STAGES; i++) r_chain[i] <= r_chain[i-1];
            r_prev <= r_chain[SYNC_STAGES-1];
        end
    end

    assign o_sync  = r_chain[SYNC_STAGES-1];
    assign w_rise  = o_sync & ~r_prev;
    assign w_fall  = ~o_sync & r_prev;
    assign o_pulse = (EDGE_TYPE == int'(EDGE_RISE)) ? w_rise :
                     (EDGE_TYPE == int'(EDGE_FALL)) ? w_fall : (w_rise | w_fall);
endmodule

// File: rtl/jtag_debug_sys_pio_ext.sv
// jtag_debug_sys_pio_ext: Avalon-MM GPIO slave with direction control,
// atomic set/clear, edge capture and a maskable level interrupt.
module jtag_debug_sys_pio_ext
    import pio_ext_pkg::*;
#(
    parameter int               WIDTH       = 32,
    parameter logic [WIDTH-1:0] RESET_VALUE = '0,
    parameter logic [WIDTH-1:0] DIR_RESET   = '1,
    parameter int               EDGE_TYPE   = 0,
    parameter int               SYNC_STAGES = 2
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [2:0]       address,
    input  logic             chipselect,
    input  logic             write_n,
    input  logic [WIDTH-1:0] writedata,
    output logic [WIDTH-1:0] readdata,
    input  logic [WIDTH-1:0] in_port,
    output logic [WIDTH-1:0] out_port,
    output logic [WIDTH-1:0] oe,
    output logic             irq
);
    logic [WIDTH-1:0] r_data, r_oe, r_mask, r_cap;
    logic [WIDTH-1:0] w_sync, w_pulse, w_clr;
    logic [2:0]       r_arm_cnt;
    arm_e             r_arm;
    logic             w_wr;

    pio_ext_in_sync #(
        .WIDTH(WIDTH), .SYNC_STAGES(SYNC_STAGES), .EDGE_TYPE(EDGE_TYPE)
    ) u_in_sync (
        .clk(clk), .i_reset_n(reset_n), .i_in(in_port), .o_sync(w_sync), .o_pulse(w_pulse)
    );

    assign w_wr  = chipselect & ~write_n;
    assign w_clr = (w_wr && address == ADDR_EDGE_CAP) ? writedata : '0;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_data    <= RESET_VALUE;
            r_oe      <= DIR_RESET;
            r_mask    <= '0;
            r_cap     <= '0;
            r_arm     <= ARMING;
            r_arm_cnt <= '0;
        end else begin
            if (w_wr && address == ADDR_DATA) r_data <= writedata;
            else if (w_wr && address == ADDR_OUTSET) r_data <= r_data | writedata;
            else if (w_wr && address == ADDR_OUTCLR) r_data <= r_data & ~writedata;
            if (w_wr && address == ADDR_DIR) r_oe <= writedata;
            if (w_wr && address == ADDR_IRQ_MASK) r_mask <= writedata;
            // set is applied after clear so a coincident edge survives a clear write
            r_cap <= (r_cap & ~w_clr) | (w_pulse & ~r_oe & {WIDTH{r_arm == ARMED}});
            if (r_arm == ARMING) begin
                r_arm     <= (r_arm_cnt == 3'(SYNC_STAGES)) ? ARMED : ARMING;
                r_arm_cnt <= r_arm_cnt + 3'd1;
            end
        end
    end

    always_comb begin
        readdata = '0;
        case (address)
            ADDR_DATA:     readdata = (r_data & r_oe) | (w_sync & ~r_oe);
            ADDR_DIR:      readdata = r_oe;
            ADDR_IRQ_MASK: readdata = r_mask;
            ADDR_EDGE_CAP: readdata = r_cap;
            default:       readdata = '0;
        endcase
    end

    assign out_port = r_data;
    assign oe       = r_oe;
    assign irq      = |(r_cap & r_mask);
endmodule

// File: tb/tb_jtag_debug_sys_pio_ext.sv
// tb_jtag_debug_sys_pio_ext: directed and randomized checks of the extended PIO
// against a history-based reference model.
module tb_jtag_debug_sys_pio_ext;
    localparam int W = 32;
    localparam int S = 2;
    localparam int S2 = 3;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic         reset_n, chipselect, write_n, irq;
    logic [2:0]   address;
    logic [W-1:0] writedata, readdata, in_port, out_port, oe;

    logic       rn2, cs2, wn2, irq2;
    logic [2:0] a2;
    logic [7:0] wd2, rd2, in2, out2, oe2;

    int n_tests = 0;
    int n_fail  = 0;

    logic [W-1:0] m_data, m_oe, m_mask, m_cap;
    logic [W-1:0] m_hist [$];
    int           m_live;

    jtag_debug_sys_pio_ext dut (
        .clk(clk), .reset_n(reset_n), .address(address), .chipselect(chipselect),
        .write_n(write_n), .writedata(writedata), .readdata(readdata), .in_port(in_port),
        .out_port(out_port), .oe(oe), .irq(irq)
    );

    jtag_debug_sys_pio_ext #(.WIDTH(8), .EDGE_TYPE(2), .SYNC_STAGES(S2)) dut2 (
        .clk(clk), .reset_n(rn2), .address(a2), .chipselect(cs2), .write_n(wn2),
        .writedata(wd2), .readdata(rd2), .in_port(in2), .out_port(out2), .oe(oe2), .irq(irq2)
    );

    task automatic chk(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    // m_hist[0] is the newest in_port sample; sync lags by S-1 samples, prev by S
    function automatic logic [W-1:0] m_read(input logic [2:0] a);
        logic [W-1:0] sync;
        sync = m_hist[S-1];
        case (a)
            3'd0: return (m_data & m_oe) | (sync & ~m_oe);
            3'd1: return m_oe;
            3'd2: return m_mask;
            3'd3: return m_cap;
            default: return '0;
        endcase
    endfunction

    task automatic m_edge();
        logic [W-1:0] rise, clr;
        logic         wr;
        if (!reset_n) begin
            m_data = '0; m_oe = '1; m_mask = '0; m_cap = '0; m_live = 0;
            m_hist.delete();
            repeat (S + 1) m_hist.push_front('0);
            return;
        end
        wr   = chipselect && !write_n;
        rise = m_hist[S-1] & ~m_hist[S];
        clr  = (wr && address == 3'd3) ? writedata : '0;
        m_cap = (m_cap & ~clr) | ((m_live >= S + 1) ? (rise & ~m_oe) : '0);
        if (wr && address == 3'd0) m_data = writedata;
        if (wr && address == 3'd4) m_data = m_data | writedata;
        if (wr && address == 3'd5) m_data = m_data & ~writedata;
        if (wr && address == 3'd1) m_oe = writedata;
        if (wr && address == 3'd2) m_mask = writedata;
        m_hist.push_front(in_port);
        if (m_hist.size() > S + 1) void'(m_hist.pop_back());
        m_live++;
    endtask

    task automatic tick();
        @(posedge clk);
        m_edge();
        #1;
        chk("out_port", out_port, m_data);
        chk("oe", oe, m_oe);
        chk("irq", irq, |(m_cap & m_mask));
        chk("readdata", readdata, m_read(address));
    endtask

    task automatic wr(input logic [2:0] a, input logic [W-1:0] d);
        chipselect = 1'b1; write_n = 1'b0; address = a; writedata = d;
        tick();
        chipselect = 1'b0; write_n = 1'b1;
    endtask

    task automatic rd_chk(input string tag, input logic [2:0] a, input logic [W-1:0] exp);
        address = a;
        #1;
        chk(tag, readdata, exp);
    endtask

    task automatic wr2(input logic [2:0] a, input logic [7:0] d);
        cs2 = 1'b1; wn2 = 1'b0; a2 = a; wd2 = d;
        @(posedge clk); #1;
        cs2 = 1'b0; wn2 = 1'b1;
    endtask

    initial begin
        repeat (S + 1) m_hist.push_front('0);
        m_live = 0;
        reset_n = 1'b0; chipselect = 1'b0; write_n = 1'b1; address = '0; writedata = '0; in_port = '0;
        rn2 = 1'b0; cs2 = 1'b0; wn2 = 1'b1; a2 = '0; wd2 = '0; in2 = '0;

        // reset state
        repeat (2) tick();
        chk("rst_out", out_port, '0);
        chk("rst_oe", oe, '1);
        chk("rst_irq", irq, 0);
        for (int a = 0; a < 8; a++) rd_chk("rst_read", 3'(a), (a == 1) ? '1 : '0);

        // DATA / OUTSET / OUTCLR
        reset_n = 1'b1;
        wr(3'd0, 32'h0000_00F0);
        chk("data_wr", out_port, 32'h0000_00F0);
        wr(3'd4, 32'h0000_000F);
        chk("outset", out_port, 32'h0000_00FF);
        wr(3'd5, 32'h0000_0030);
        chk("outclr", out_port, 32'h0000_00CF);

        // edge capture latency on bit 16
        wr(3'd1, 32'h0000_FFFF);
        wr(3'd2, 32'h0001_0000);
        repeat (4) tick();
        in_port[16] = 1'b1;
        for (int i = 1; i <= S + 1; i++) begin
            tick();
            chk("irq_latency", irq, (i == S + 1) ? 1'b1 : 1'b0);
        end
        rd_chk("cap_set", 3'd3, 32'h0001_0000);
        wr(3'd3, 32'h0001_0000);
        chk("cap_clr_irq", irq, 0);
        rd_chk("cap_clr", 3'd3, '0);

        // clear write coinciding with a new capture
        in_port[16] = 1'b0;
        repeat (4) tick();
        in_port[16] = 1'b1;
        repeat (S) tick();
        wr(3'd3, 32'h0001_0000);
        chk("set_wins_irq", irq, 1);
        rd_chk("set_wins_cap", 3'd3, 32'h0001_0000);

        // all-ones input through reset must not produce captures while arming
        reset_n = 1'b0; in_port = '1;
        repeat (3) tick();
        reset_n = 1'b1;
        wr(3'd1, '0);
        repeat (6) tick();
        rd_chk("arm_nocap", 3'd3, '0);
        wr(3'd1, 32'h0000_FFFF);
        for (int i = 0; i < 4; i++) begin
            in_port[5] = ~in_port[5];
            repeat (3) tick();
        end
        rd_chk("out_dir_nocap", 3'd3, '0);

        // randomized traffic against the model
        for (int c = 0; c < 500; c++) begin
            reset_n    = ($urandom_range(0, 99) != 0);
            chipselect = 1'($urandom_range(0, 1));
            write_n    = 1'($urandom_range(0, 1));
            address    = 3'($urandom_range(0, 7));
            writedata  = $urandom;
            if ($urandom_range(0, 2) == 0) in_port = $urandom;
            tick();
        end
        chipselect = 1'b0; write_n = 1'b1;

        // any-edge instance, 8 bits
        @(posedge clk); #1;
        rn2 = 1'b1;
        wr2(3'd1, 8'h00);
        repeat (6) @(posedge clk);
        #1;
        in2 = 8'h08;
        @(posedge clk); #1;
        in2 = 8'h00;
        repeat (8) @(posedge clk);
        #1;
        a2 = 3'd3;
        #1;
        chk("any_cap", rd2, 8'h08);
        chk("any_nomask_irq", irq2, 0);
        wr2(3'd2, 8'h08);
        chk("any_mask_irq", irq2, 1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
